// File: rtl/sync_norm_pkg.sv
// Shared constants, status type and length arithmetic for the sync polarity normaliser.
package sync_norm_pkg;

   localparam int CW_DEF       = 16;
   localparam int LOCK_CNT_DEF = 3;
   localparam int STAB_W       = 4;   // holds LOCK_CNT values 1..15

   typedef struct packed {
      logic pol;
      logic locked;
      logic active;
   } chan_status_t;

   // Saturating +1 on a phase length; callers truncate back to their counter width.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v >= max) ? max : v + 32'd1;
   endfunction

endpackage

// File: rtl/sync_norm_chan.sv
// One sync channel: synchroniser, phase measurement, polarity hysteresis and timeout.
module sync_norm_chan
   import sync_norm_pkg::*;
#(
   parameter int CW       = CW_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
)
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         sync_in,
   output logic         sync_out,
   output chan_status_t status,
   output logic [CW:0]  period
);

   localparam logic [CW-1:0]     CNT_MAX  = '1;
   localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_CNT);
   localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

   logic              s1, s2;
   logic [CW-1:0]     cnt, low_len, len;
   logic              lv, cand, pol, locked, active;
   logic [STAB_W-1:0] stab;
   logic              rise, fall, edge_seen, timeout, cand_new;

   assign rise      = s1 & ~s2;
   assign fall      = s2 & ~s1;
   assign edge_seen = s1 ^ s2;
   assign len       = CW'(sat_inc(32'(cnt), 32'(CNT_MAX)));
   // Fires on the cycle cnt steps onto its ceiling; an edge in that cycle wins.
   assign timeout   = ~edge_seen & (cnt == (CNT_MAX - CNT_ONE));
   // The new high phase is consumed directly at the falling edge, so it needs no holding register.
   assign cand_new  = (len > low_len);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         sync_out <= 1'b0;
         cnt      <= '0;
         low_len  <= '0;
         lv       <= 1'b0;
         cand     <= 1'b0;
         stab     <= '0;
         pol      <= 1'b0;
         locked   <= 1'b0;
         active   <= 1'b0;
         period   <= '0;
      end else begin
         s1       <= sync_in;
         s2       <= s1;
         sync_out <= s2 ^ pol;

         if (edge_seen)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_ONE;

         if (edge_seen)
            active <= 1'b1;

         if (rise) begin
            low_len <= len;
            lv      <= 1'b1;
         end

         if (fall && lv) begin
            period <= {1'b0, len} + {1'b0, low_len};
            if (cand_new == cand) begin
               if (stab != STAB_MAX)
                  stab <= stab + STAB_ONE;
            end else begin
               cand <= cand_new;
               stab <= STAB_ONE;
            end
         end

         // Outputs follow the hysteresis state one cycle after a decision.
         locked <= (stab == STAB_MAX);
         if (stab == STAB_MAX)
            pol <= cand;

         if (timeout) begin
            active <= 1'b0;
            lv     <= 1'b0;
            stab   <= '0;
            locked <= 1'b0;
            pol    <= 1'b0;
         end
      end
   end

   assign status.pol    = pol;
   assign status.locked = locked;
   assign status.active = active;

endmodule

// File: rtl/sync_polarity_norm.sv
// Multi-channel sync polarity normaliser: active-high syncs plus per-channel status.
module sync_polarity_norm
   import sync_norm_pkg::*;
#(
   parameter int CH       = 2,
   parameter int CW       = CW_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [CH-1:0]         sync_in,
   output logic [CH-1:0]         sync_out,
   output logic [CH-1:0]         pol,
   output logic [CH-1:0]         locked,
   output logic [CH-1:0]         active,
   output logic [CH*(CW+1)-1:0]  period
);

   chan_status_t [CH-1:0]  st;
   logic [CH-1:0][CW:0]    period_arr;

   for (genvar i = 0; i < CH; i++) begin : g_chan
      sync_norm_chan #(
         .CW       (CW),
         .LOCK_CNT (LOCK_CNT)
      ) u_chan (
         .clk      (clk),
         .reset_n  (reset_n),
         .sync_in  (sync_in[i]),
         .sync_out (sync_out[i]),
         .status   (st[i]),
         .period   (period_arr[i])
      );

      assign pol[i]    = st[i].pol;
      assign locked[i] = st[i].locked;
      assign active[i] = st[i].active;
   end

   assign period = period_arr;

endmodule

// File: tb/tb_sync_polarity_norm.sv
// Directed bench for sync_polarity_norm: polarity, lock, glitch, reset, timeout and channel checks.
module tb_sync_polarity_norm;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   // main instance: CH=1, CW=16, LOCK_CNT=3
   logic        sa, sync_out_a, pol_a, locked_a, active_a;
   logic [16:0] period_a;
   // timeout instance: CH=1, CW=8
   logic        st_in, sync_out_t, pol_t, locked_t, active_t;
   logic [8:0]  period_t;
   // two-channel instance
   logic [1:0]  sc, sync_out_c, pol_c, locked_c, active_c;
   logic [33:0] period_c;

   sync_polarity_norm #(.CH(1), .CW(16), .LOCK_CNT(3)) dut_a (
      .clk(clk), .reset_n(rst_n), .sync_in(sa), .sync_out(sync_out_a),
      .pol(pol_a), .locked(locked_a), .active(active_a), .period(period_a));

   sync_polarity_norm #(.CH(1), .CW(8), .LOCK_CNT(3)) dut_t (
      .clk(clk), .reset_n(rst_n), .sync_in(st_in), .sync_out(sync_out_t),
      .pol(pol_t), .locked(locked_t), .active(active_t), .period(period_t));

   sync_polarity_norm #(.CH(2), .CW(16), .LOCK_CNT(3)) dut_c (
      .clk(clk), .reset_n(rst_n), .sync_in(sc), .sync_out(sync_out_c),
      .pol(pol_c), .locked(locked_c), .active(active_c), .period(period_c));

   int   errors = 0;
   int   checks = 0;
   logic [2:0] hist_a;
   logic out_chk, out_inv;
   logic lk2, pol2, lk3, pol3;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // drive one cycle on dut_a; sync_out must equal the input from 3 edges back
   task automatic step_a(input logic v);
      sa     = v;
      hist_a = {hist_a[1:0], v};
      @(negedge clk);
      if (out_chk) chk("sync_out_a", 32'(sync_out_a), 32'(hist_a[2] ^ out_inv));
   endtask

   // one low-then-high period; the falling edge at its start is sampled 2 and 3 cycles on
   task automatic per_a(input int nlo, input int nhi);
      step_a(1'b0);
      step_a(1'b0);
      lk2 = locked_a; pol2 = pol_a;
      step_a(1'b0);
      lk3 = locked_a; pol3 = pol_a;
      repeat (nlo - 3) step_a(1'b0);
      repeat (nhi) step_a(1'b1);
   endtask

   task automatic st_per(input int nlo, input int nhi);
      st_in = 1'b0;
      repeat (nlo) @(negedge clk);
      st_in = 1'b1;
      repeat (nhi) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; sa = 1'b0; st_in = 1'b0; sc = '0;
      hist_a = '0; out_chk = 1'b0; out_inv = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sync_out", 32'(sync_out_a), 0);
      chk("rst_pol",      32'(pol_a), 0);
      chk("rst_locked",   32'(locked_a), 0);
      chk("rst_active",   32'(active_a), 0);
      chk("rst_period",   32'(period_a), 0);
      rst_n = 1'b1;

      // active-high 10/90: never inverted, locks on the 3rd decision
      for (int p = 1; p <= 5; p++) begin
         out_chk = (p == 5);
         per_a(90, 10);
         if (p == 2 || p == 3) chk("t1_lock_early", 32'(lk3), 0);
         if (p == 4) begin
            chk("t1_lock_n2", 32'(lk2), 0);
            chk("t1_lock_n3", 32'(lk3), 1);
         end
         if (p >= 2) chk("t1_pol", 32'(pol3), 0);
         if (p >= 3) chk("t1_period", 32'(period_a), 100);
      end
      out_chk = 1'b0;

      // active-low 10/90: pol flips one cycle after the 3rd decision
      rst_n = 1'b0;
      repeat (3) step_a(1'b0);
      rst_n = 1'b1;
      out_inv = 1'b1;
      for (int p = 1; p <= 5; p++) begin
         out_chk = (p == 5);
         per_a(10, 90);
         if (p == 2 || p == 3) begin
            chk("t2_pol_early",  32'(pol3), 0);
            chk("t2_lock_early", 32'(lk3), 0);
         end
         if (p == 4) begin
            chk("t2_pol_n2",  32'(pol2), 0);
            chk("t2_pol_n3",  32'(pol3), 1);
            chk("t2_lock_n3", 32'(lk3), 1);
            chk("t2_period",  32'(period_a), 100);
         end
      end

      // one inverted period: locked drops, pol (and the inverted output) holds
      out_chk = 1'b1;
      per_a(90, 10);
      chk("t3_lock_pre", 32'(lk3), 1);
      for (int g = 1; g <= 4; g++) begin
         per_a(10, 90);
         chk("t3_pol", 32'(pol3), 1);
         chk("t3_lock", 32'(lk3), (g == 4) ? 1 : 0);
      end
      out_chk = 1'b0;

      // asynchronous reset while locked
      repeat (5) step_a(1'b0);
      chk("t5_pre_out",    32'(sync_out_a), 1);
      chk("t5_pre_locked", 32'(locked_a), 1);
      chk("t5_pre_active", 32'(active_a), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_sync_out", 32'(sync_out_a), 0);
      chk("t5_pol",      32'(pol_a), 0);
      chk("t5_locked",   32'(locked_a), 0);
      chk("t5_active",   32'(active_a), 0);
      chk("t5_period",   32'(period_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      per_a(10, 90);
      chk("t5_period_hold", 32'(period_a), 0);
      per_a(10, 90);
      per_a(10, 90);
      chk("t5_period_new", 32'(period_a), 100);

      // timeout on the CW=8 instance
      for (int p = 1; p <= 5; p++) st_per(10, 90);
      st_in = 1'b0;
      repeat (256) @(negedge clk);
      chk("t4_active_pre", 32'(active_t), 1);
      chk("t4_locked_pre", 32'(locked_t), 1);
      chk("t4_pol_pre",    32'(pol_t), 1);
      chk("t4_period",     32'(period_t), 100);
      @(negedge clk);
      chk("t4_active", 32'(active_t), 0);
      chk("t4_locked", 32'(locked_t), 0);
      chk("t4_pol",    32'(pol_t), 0);
      for (int p = 1; p <= 5; p++) st_per(10, 90);
      st_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_relock",  32'(locked_t), 1);
      chk("t4_repol",   32'(pol_t), 1);
      chk("t4_reactive", 32'(active_t), 1);

      // two independent channels
      for (int t = 0; t < 2600; t++) begin
         sc[0] = ((t % 64) >= 4);
         sc[1] = ((t % 502) < 2);
         @(negedge clk);
         if (t == 700) begin
            chk("t6_lock_700", 32'(locked_c), 1);
            chk("t6_pol_700",  32'(pol_c), 1);
         end
         if (t == 1100) chk("t6_lock_1100", 32'(locked_c), 3);
      end
      chk("t6_pol",     32'(pol_c), 1);
      chk("t6_active",  32'(active_c), 3);
      chk("t6_period0", 32'(period_c[16:0]), 64);
      chk("t6_period1", 32'(period_c[33:17]), 502);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
